// File: rtl/sync_param_fifo.sv
// sync_param_fifo: single-clock parametrised FIFO on a dual-port RAM array.
//
// Parameters:
//   DATA_W    - data word width in bits
//   ADDR_W    - address width, DEPTH = 2**ADDR_W (ADDR_W >= 2)
//   AFULL_TH  - almost_full when count >= AFULL_TH
//   AEMPTY_TH - almost_empty when count <= AEMPTY_TH
//
// Ports:
//   clk          - single clock, rising edge
//   clr_n        - asynchronous active-low reset
//   we, re       - write / read requests
//   data_in      - write data
//   data_out     - registered read data, valid one cycle after an accepted read
//   full, empty, almost_full, almost_empty - registered status flags
//   count        - occupancy 0..DEPTH
//   overflow     - one-cycle pulse per rejected write
//   underflow    - one-cycle pulse per rejected read
//   parity_err   - bad-parity indication for the word on data_out
//
// Optional feature macro: SYNC_FIFO_PARITY_EN
//   Defined   : each RAM entry carries an even-parity bit, checked on read.
//   Undefined : RAM is DATA_W wide and parity_err is tied to 0.

module sync_param_fifo #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned AFULL_TH  = 6,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              we,
    input  logic              re,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              parity_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
`ifdef SYNC_FIFO_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W-1:0] next_count;
    logic             wr_ok;
    logic             rd_ok;
    logic [MEM_W-1:0] wr_word;
    logic [MEM_W-1:0] rd_word;

    // Accept decisions use the registered flags; occupancy follows both.
    always_comb begin
        wr_ok      = we & ~full;
        rd_ok      = re & ~empty;
        next_count = count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    end

    // Stored word: data, plus its even-parity bit in the MSB when enabled.
`ifdef SYNC_FIFO_PARITY_EN
    assign wr_word = {^data_in, data_in};
`else
    assign wr_word = data_in;
`endif

    assign rd_word = mem[rd_ptr[ADDR_W-1:0]];

    // RAM array: no reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (clr_n && wr_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_word;
        end
    end

    // Pointers, occupancy, flags and read data.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_out     <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + CNT_W'(1);
            end
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + CNT_W'(1);
                data_out <= rd_word[DATA_W-1:0];
            end
            count        <= next_count;
            // Flags derive from next_count so they always agree with count.
            full         <= (next_count == CNT_W'(DEPTH));
            empty        <= (next_count == '0);
            almost_full  <= (next_count >= CNT_W'(AFULL_TH));
            almost_empty <= (next_count <= CNT_W'(AEMPTY_TH));
            overflow     <= we & full;
            underflow    <= re & empty;
        end
    end

`ifdef SYNC_FIFO_PARITY_EN
    // Parity flag travels with data_out and only lasts for the read cycle.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= rd_ok & (^rd_word);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
